// File: rtl/perf_mon_pkg.sv
// Shared types and select constants for the pipeline performance monitor.
package perf_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam int SEL_CYCLE    = 0;
    localparam int EVT_SEL_BASE = 1;

endpackage

// File: rtl/pipe_perf_monitor_if.sv
// Counter read port of the performance monitor, grouped as one interface.
interface pipe_perf_monitor_if #(
    parameter int CNT_W = 32,
    parameter int SEL_W = 4
);
    // rd_req_i is a one-cycle strobe sampled on every rising edge with no
    // back-pressure; each accepted strobe yields exactly one rd_ack_o pulse on
    // the following edge, carrying rd_data_o/rd_err_o for that request.
    logic             rd_req_i;
    logic [SEL_W-1:0] rd_sel_i;
    logic             rd_ack_o;
    logic [CNT_W-1:0] rd_data_o;
    logic             rd_err_o;

    modport master (
        output rd_req_i, rd_sel_i,
        input  rd_ack_o, rd_data_o, rd_err_o
    );

    modport slave (
        input  rd_req_i, rd_sel_i,
        output rd_ack_o, rd_data_o, rd_err_o
    );

endinterface

// File: rtl/perf_counter.sv
// Single event counter with synchronous clear.
// PERF_SATURATE_EN selects saturation with a sticky overflow flag; otherwise it wraps.
module perf_counter
    import perf_mon_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

`ifdef PERF_SATURATE_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (&cnt) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/pipe_perf_monitor.sv
// Run-cycle and event counters with a programmable halt limit and a registered read port.
// PERF_SATURATE_EN (in perf_counter) switches counters from wrapping to saturating.
module pipe_perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 32,
    parameter int SEL_W   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               clr_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [CNT_W-1:0]   limit_i,
    output logic               halt_o,
    output logic               running_o,
    output logic               ovf_o,
    output state_t             state_o,
    pipe_perf_monitor_if.slave rd
);

    localparam int NUM_CNT = NUM_EVT + 1;

    state_t           state_q, state_d;
    logic             run;
    logic [NUM_CNT-1:0] inc_vec, ovf_vec;
    logic [CNT_W-1:0] cnt_arr [NUM_CNT];
    logic [CNT_W-1:0] cyc_next, sel_data;
    logic             sel_ok;

    assign run = (state_q == ST_RUN);

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        if (k == SEL_CYCLE) begin : g_cyc
            assign inc_vec[k] = run;
        end else begin : g_evt
            assign inc_vec[k] = run & evt_i[k-EVT_SEL_BASE];
        end
        perf_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr   (clr_i),
            .inc   (inc_vec[k]),
            .cnt   (cnt_arr[k]),
            .ovf   (ovf_vec[k])
        );
    end

    // A saturated cycle counter yields cyc_next == 0, which never matches a non-zero limit.
    assign cyc_next = cnt_arr[SEL_CYCLE] + CNT_W'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_RUN;
            ST_RUN: begin
                if ((limit_i != '0) && (cyc_next == limit_i)) state_d = ST_HALTED;
                else if (!start_i)                            state_d = ST_IDLE;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
        if (clr_i) state_d = ST_IDLE;
    end

    assign running_o = (state_q == ST_RUN);
    assign halt_o    = (state_q == ST_HALTED);
    assign state_o   = state_q;
    assign ovf_o     = |ovf_vec;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (rd.rd_sel_i == SEL_W'(k)) sel_data = cnt_arr[k];
        end
    end

    assign sel_ok = (int'(rd.rd_sel_i) < NUM_CNT);

    // Data is captured from the pre-increment counter value, so a read issued
    // alongside an event or a clear reports the value before that edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd.rd_ack_o  <= 1'b0;
            rd.rd_data_o <= '0;
            rd.rd_err_o  <= 1'b0;
        end else begin
            rd.rd_ack_o <= rd.rd_req_i;
            if (rd.rd_req_i) begin
                rd.rd_data_o <= sel_data;
                rd.rd_err_o  <= !sel_ok;
            end else begin
                rd.rd_err_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed scoreboard bench for pipe_perf_monitor (32-bit and 4-bit counter instances).
module tb_pipe_perf_monitor;
    import perf_mon_pkg::*;

    localparam int NUM_EVT = 4;
    localparam int CNT_W   = 32;
    localparam int SEL_W   = 4;
    localparam int W4      = 4;

`ifdef PERF_SATURATE_EN
    localparam logic [W4-1:0] EXP4_EVT = 4'd15;
    localparam logic [W4-1:0] EXP4_CYC = 4'd15;
    localparam logic          EXP4_OVF = 1'b1;
`else
    localparam logic [W4-1:0] EXP4_EVT = 4'd4;
    localparam logic [W4-1:0] EXP4_CYC = 4'd5;
    localparam logic          EXP4_OVF = 1'b0;
`endif

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic               start, clr, halt, running, ovf;
    logic [NUM_EVT-1:0] evt;
    logic [CNT_W-1:0]   limit;
    state_t             state;

    logic               start4, clr4, halt4, running4, ovf4;
    logic [NUM_EVT-1:0] evt4;
    logic [W4-1:0]      limit4;
    state_t             state4;

    pipe_perf_monitor_if #(.CNT_W(CNT_W), .SEL_W(SEL_W)) rd_if ();
    pipe_perf_monitor_if #(.CNT_W(W4),    .SEL_W(SEL_W)) rd4_if ();

    pipe_perf_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .clr_i(clr), .evt_i(evt),
        .limit_i(limit), .halt_o(halt), .running_o(running), .ovf_o(ovf),
        .state_o(state), .rd(rd_if)
    );

    pipe_perf_monitor #(.NUM_EVT(NUM_EVT), .CNT_W(W4), .SEL_W(SEL_W)) dut4 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start4), .clr_i(clr4), .evt_i(evt4),
        .limit_i(limit4), .halt_o(halt4), .running_o(running4), .ovf_o(ovf4),
        .state_o(state4), .rd(rd4_if)
    );

    // scoreboard: expected {err, data} per read request
    logic [CNT_W:0] exp_q[$];
    logic [W4:0]    exp4_q[$];
    logic [CNT_W:0] e_main;
    logic [W4:0]    e_4;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_if.rd_ack_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected_ack", 32'(rd_if.rd_ack_o), 32'd0);
            end else begin
                e_main = exp_q.pop_front();
                check("rd_data", rd_if.rd_data_o, e_main[CNT_W-1:0]);
                check("rd_err", 32'(rd_if.rd_err_o), 32'(e_main[CNT_W]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rd4_if.rd_ack_o === 1'b1) begin
            if (exp4_q.size() == 0) begin
                check("rd4_unexpected_ack", 32'(rd4_if.rd_ack_o), 32'd0);
            end else begin
                e_4 = exp4_q.pop_front();
                check("rd4_data", 32'(rd4_if.rd_data_o), 32'(e_4[W4-1:0]));
                check("rd4_err", 32'(rd4_if.rd_err_o), 32'(e_4[W4]));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] d, input logic err);
        rd_if.rd_req_i = 1'b1;
        rd_if.rd_sel_i = sel;
        exp_q.push_back({err, d});
        tick();
    endtask

    task automatic do_read4(input logic [SEL_W-1:0] sel, input logic [W4-1:0] d, input logic err);
        rd4_if.rd_req_i = 1'b1;
        rd4_if.rd_sel_i = sel;
        exp4_q.push_back({err, d});
        tick();
    endtask

    task automatic rd_idle();
        rd_if.rd_req_i  = 1'b0;
        rd4_if.rd_req_i = 1'b0;
        tick();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && (exp_q.size() != 0 || exp4_q.size() != 0); i++) tick();
        check(name, 32'(exp_q.size() + exp4_q.size()), 32'd0);
    endtask

    initial begin
        start = 0; clr = 0; evt = '0; limit = '0;
        start4 = 0; clr4 = 0; evt4 = '0; limit4 = '0;
        rd_if.rd_req_i = 0;  rd_if.rd_sel_i = '0;
        rd4_if.rd_req_i = 0; rd4_if.rd_sel_i = '0;

        #1 rst_n = 1'b0;
        #1;
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_ack", 32'(rd_if.rd_ack_o), 32'd0);
        check("rst_data", rd_if.rd_data_o, 32'd0);
        check("rst_err", 32'(rd_if.rd_err_o), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        #20 rst_n = 1'b1;
        tick();

        // limit 30, evt[0] on counted cycles 3, 4, 10
        limit = 32'd30;
        start = 1'b1;
        tick();
        check("t1_running", 32'(running), 32'd1);
        for (int i = 1; i <= 30; i++) begin
            evt = (i == 3 || i == 4 || i == 10) ? 4'b0001 : 4'b0000;
            if (i == 30) check("t1_pre_halt", 32'(halt), 32'd0);
            tick();
        end
        evt = '0;
        check("t1_halt", 32'(halt), 32'd1);
        check("t1_running_off", 32'(running), 32'd0);
        evt = 4'b0001;
        tick();
        tick();
        evt = '0;
        check("t1_halt_hold", 32'(halt), 32'd1);
        do_read(4'd5, 32'd0, 1'b1);
        do_read(4'd1, 32'd3, 1'b0);
        do_read(4'd2, 32'd0, 1'b0);
        do_read(4'd0, 32'd30, 1'b0);
        rd_idle();
        drain("t1_drain");
        check("t1_ack_low", 32'(rd_if.rd_ack_o), 32'd0);
        check("t1_data_hold", rd_if.rd_data_o, 32'd30);

        // clear while halted; same-cycle read sees the pre-clear value
        start = 1'b0;
        clr = 1'b1;
        do_read(4'd0, 32'd30, 1'b0);
        clr = 1'b0;
        check("clr_halt", 32'(halt), 32'd0);
        check("clr_state", 32'(state), 32'(ST_IDLE));
        for (int s = 0; s <= NUM_EVT; s++) do_read(SEL_W'(s), 32'd0, 1'b0);
        rd_idle();
        drain("clr_drain");

        // pause/resume with no limit: 5 high, 4 low, 3 high
        limit = '0;
        start = 1'b1;
        repeat (5) tick();
        check("t2_running_a", 32'(running), 32'd1);
        start = 1'b0;
        tick();
        check("t2_paused", 32'(running), 32'd0);
        repeat (3) tick();
        start = 1'b1;
        repeat (3) tick();
        check("t2_running_b", 32'(running), 32'd1);
        start = 1'b0;
        tick();
        check("t2_running_off", 32'(running), 32'd0);
        check("t2_no_halt", 32'(halt), 32'd0);
        do_read(4'd0, 32'd8, 1'b0);
        do_read(4'd1, 32'd0, 1'b0);
        rd_idle();
        drain("t2_drain");

        // read coincident with an event: counter at 7 reads 7, then 8
        clr = 1'b1;
        tick();
        clr = 1'b0;
        start = 1'b1;
        tick();
        evt = 4'b0010;
        repeat (7) tick();
        do_read(4'd2, 32'd7, 1'b0);
        evt = '0;
        do_read(4'd2, 32'd8, 1'b0);
        do_read(4'd0, 32'd9, 1'b0);
        rd_idle();
        drain("t3_drain");
        check("t3_data_hold", rd_if.rd_data_o, 32'd9);

        // asynchronous reset while running
        evt = 4'b1111;
        check("t4_running_pre", 32'(running), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_running", 32'(running), 32'd0);
        check("arst_halt", 32'(halt), 32'd0);
        check("arst_data", rd_if.rd_data_o, 32'd0);
        check("arst_ack", 32'(rd_if.rd_ack_o), 32'd0);
        check("arst_state", 32'(state), 32'(ST_IDLE));
        check("arst_ovf", 32'(ovf), 32'd0);
        start = 1'b0;
        evt = '0;
        #2 rst_n = 1'b1;
        tick();
        do_read(4'd0, 32'd0, 1'b0);
        do_read(4'd3, 32'd0, 1'b0);
        rd_idle();
        drain("arst_drain");

        // 4-bit counters: evt[0] high for 20 run cycles, 21 run cycles total
        start4 = 1'b1;
        tick();
        evt4 = 4'b0001;
        repeat (20) tick();
        evt4 = '0;
        start4 = 1'b0;
        tick();
        check("w4_ovf", 32'(ovf4), 32'(EXP4_OVF));
        check("w4_halt", 32'(halt4), 32'd0);
        check("w4_running", 32'(running4), 32'd0);
        check("w4_state", 32'(state4), 32'(ST_IDLE));
        do_read4(4'd1, EXP4_EVT, 1'b0);
        do_read4(4'd0, EXP4_CYC, 1'b0);
        do_read4(4'd2, 4'd0, 1'b0);
        do_read4(4'd5, 4'd0, 1'b1);
        rd_idle();
        drain("w4_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
Synthesizable performance monitor for the 5-stage pipelined CPU. It replaces bench-side stall/flush counting and the fixed-cycle stop with an in-design counter block. It counts run cycles plus NUM_EVT per-cycle event strobes (stall, flush, retire, ...) and requests a halt after a programmable cycle limit. Counters are read through a one-cycle request/acknowledge port. The block sits beside the hazard/flush units inside CPU and is observed by the bench.

Parameters:
NUM_EVT, 4, number of event inputs/counters (1..15)
CNT_W, 32, width of every counter and of limit_i
SEL_W, 4, width of rd_sel_i; must satisfy 2^SEL_W >= NUM_EVT+1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  run enable (level)
clr_i  in  1  synchronous clear of all counters and state
evt_i  in  NUM_EVT  event strobes, bit k counts into event counter k
limit_i  in  CNT_W  cycle limit; 0 = unlimited
halt_o  out  1  high while in HALTED
running_o  out  1  high while in RUN
rd_req_i  in  1  read request strobe
rd_sel_i  in  SEL_W  0 = cycle counter, k+1 = event counter k
rd_ack_o  out  1  one-cycle read acknowledge
rd_data_o  out  CNT_W  read data, valid when rd_ack_o=1
rd_err_o  out  1  with rd_ack_o: rd_sel_i out of range
ovf_o  out  1  OR of sticky overflow flags (optional feature)

Behaviour:
- Reset (rst_i=0, async): state IDLE, all counters 0, halt_o=0, running_o=0, rd_ack_o=0, rd_data_o=0, rd_err_o=0, ovf_o=0.
- States: IDLE, RUN, HALTED.
  - IDLE -> RUN when start_i=1.
  - RUN -> IDLE when start_i=0. This is a pause; counters hold.
  - RUN -> HALTED when an increment makes cycle_cnt equal limit_i (limit_i != 0).
  - HALTED holds until clr_i or reset; start_i is ignored there.
- Counting happens only in RUN:
  - cycle_cnt increments by 1 each RUN cycle.
  - Event counter k increments by 1 on each RUN cycle with evt_i[k]=1.
  - Events in IDLE or HALTED are ignored.
- Halt timing: with limit_i=L, exactly L RUN cycles are counted. halt_o rises the cycle after the L-th counted cycle. Events in the L-th cycle are counted.
- limit_i is sampled every cycle. If limit_i is lowered to or below the current cycle_cnt, no halt occurs; counting continues until wrap or saturation.
- clr_i takes priority over every other input:
  - Next edge: all counters 0, ovf flags 0, state IDLE, halt_o=0.
  - A read in the same cycle returns the pre-clear value.
- Read port:
  - rd_req_i sampled at edge T; at edge T+1, rd_ack_o=1 for exactly one cycle.
  - rd_data_o is the selected counter value as it was before edge T's increment.
  - Out-of-range select: rd_data_o=0, rd_err_o=1.
  - Back-to-back requests are accepted every cycle, so rd_ack_o can stay high continuously.
  - rd_data_o holds its last value when rd_ack_o=0.
- Overflow behaviour at counter maximum is defined under Optional Feature.

Optional Feature:
PERF_SATURATE_EN
- Defined: every counter saturates at 2^CNT_W-1. An increment attempted at max sets that counter's sticky ovf flag. ovf_o is the OR of all flags; flags clear only on reset or clr_i.
- Undefined: counters wrap modulo 2^CNT_W; ovf_o is tied 0. Halt on limit still works; after wrap, cycle_cnt can hit limit_i again.

Decomposition:
- Package perf_mon_pkg:
  - state enum (IDLE/RUN/HALTED)
  - SEL_CYCLE=0 constant
  - EVT_SEL_BASE=1 constant
- Sub-module perf_counter (CNT_W): one counter with inc, clr, and (under the macro) saturation plus sticky ovf. Instantiated NUM_EVT+1 times via generate.

Test Plan:
- Reset, start_i=1, limit_i=30, evt_i[0] pulsed on cycles 3,4,10 -> halt_o rises after 30 counted cycles. Reading sel 0 gives 30; reading sel 1 gives 3.
- start_i high 5 cycles, low 4, high 3 (limit_i=0) -> cycle_cnt=8, running_o tracks start_i, halt_o stays 0.
- Read request issued in the same cycle as evt_i[1]=1, with counter at 7 -> rd_ack_o next cycle with data 7; a following read returns 8.
- rd_sel_i=NUM_EVT+1 -> rd_ack_o=1, rd_err_o=1, rd_data_o=0.
- clr_i while HALTED with counters non-zero -> next cycle state IDLE, all reads 0, halt_o=0. rst_i asserted mid-RUN forces all outputs to reset values immediately (asynchronously).
- CNT_W=4, evt_i[0] held high 20 RUN cycles -> with PERF_SATURATE_EN: counter 15, ovf_o=1. Without it: counter 4 (20 mod 16), ovf_o=0.
